// File: rtl/traffic_lamp_guard_if.sv
// traffic_lamp_guard_if: controller lamp requests in, guarded lamp drive and fault status out
interface traffic_lamp_guard_if;
    logic       red1_in, yellow1_in, green1_in, red2_in, yellow2_in, green2_in;
    logic       lamp_red1, lamp_yellow1, lamp_green1, lamp_red2, lamp_yellow2, lamp_green2;
    logic       fault;
    logic [2:0] fault_code;
    modport master (
        output red1_in, yellow1_in, green1_in, red2_in, yellow2_in, green2_in,
        input  lamp_red1, lamp_yellow1, lamp_green1, lamp_red2, lamp_yellow2, lamp_green2, fault, fault_code
    );
    modport slave (
        input  red1_in, yellow1_in, green1_in, red2_in, yellow2_in, green2_in,
        output lamp_red1, lamp_yellow1, lamp_green1, lamp_red2, lamp_yellow2, lamp_green2, fault, fault_code
    );
endinterface

// File: rtl/traffic_lamp_guard.sv
// traffic_lamp_guard: registers controller lamp signals and latches a flashing-yellow fail-safe on unsafe patterns
module traffic_lamp_guard #(
    parameter int unsigned STARTUP_CYCLES      = 50_000_000,
    parameter int unsigned FAULT_FILTER_CYCLES = 4,
    parameter int unsigned WATCHDOG_CYCLES     = 1_600_000_000,
    parameter int unsigned BLINK_HALF_CYCLES   = 25_000_000
) (
    input logic                  clk,
    input logic                  rst,
    traffic_lamp_guard_if.slave  bus
);
    typedef enum logic [1:0] {STARTUP, PASS, FLASH} state_t;
    localparam logic [5:0] ALL_RED = 6'b100_100;
    state_t      r_state;
    logic [31:0] r_tmr, r_bad_cnt, r_wd_cnt;
    logic [5:0]  r_lamp, r_prev_in;
    logic [2:0]  r_prev1, r_prev2, r_code;
    logic        r_pv1, r_pv2, r_fault;
    logic [5:0]  w_in;
    logic [2:0]  w_s1, w_s2, w_code;
    logic        w_v1, w_v2, w_conf, w_bad, w_bad_flt, w_ill, w_chg, w_wd_flt, w_tog;
    // Each side is packed {red, yellow, green}; legal progression G->Y->R->G is a left rotate
    assign w_in      = {bus.red1_in, bus.yellow1_in, bus.green1_in, bus.red2_in, bus.yellow2_in, bus.green2_in};
    assign w_s1      = w_in[5:3];
    assign w_s2      = w_in[2:0];
    assign w_v1      = $onehot(w_s1);
    assign w_v2      = $onehot(w_s2);
    assign w_conf    = (|w_s1[1:0]) & (|w_s2[1:0]);
    assign w_bad     = w_conf | !(w_v1 && w_v2);
    assign w_bad_flt = w_bad && (r_bad_cnt >= FAULT_FILTER_CYCLES - 32'd1);
    assign w_ill     = (w_v1 && r_pv1 && !(w_s1 == r_prev1 || w_s1 == {r_prev1[1:0], r_prev1[2]}))
                     | (w_v2 && r_pv2 && !(w_s2 == r_prev2 || w_s2 == {r_prev2[1:0], r_prev2[2]}));
    assign w_chg     = w_in != r_prev_in;
    assign w_wd_flt  = !w_chg && (r_wd_cnt >= WATCHDOG_CYCLES - 32'd1);
    assign w_tog     = r_tmr >= BLINK_HALF_CYCLES - 32'd1;
    assign w_code    = (w_bad_flt && w_conf) ? 3'b001 : w_ill ? 3'b011 : w_bad_flt ? 3'b010 : w_wd_flt ? 3'b100 : 3'b000;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= STARTUP;
            r_tmr     <= '0;
            r_bad_cnt <= '0;
            r_wd_cnt  <= '0;
            r_lamp    <= ALL_RED;
            r_prev_in <= '0;
            r_prev1   <= '0;
            r_prev2   <= '0;
            r_pv1     <= 1'b0;
            r_pv2     <= 1'b0;
            r_fault   <= 1'b0;
            r_code    <= 3'b000;
        end else begin
            r_prev_in <= w_in;
            if (w_v1) begin
                r_prev1 <= w_s1;
                r_pv1   <= 1'b1;
            end
            if (w_v2) begin
                r_prev2 <= w_s2;
                r_pv2   <= 1'b1;
            end
            if (r_state == STARTUP) begin
                r_lamp   <= ALL_RED;
                r_wd_cnt <= '0;
                r_tmr    <= (r_tmr >= STARTUP_CYCLES - 32'd1) ? '0 : r_tmr + 32'd1;
                if (r_tmr >= STARTUP_CYCLES - 32'd1) r_state <= PASS;
            end else if (r_state == PASS) begin
                r_bad_cnt <= w_bad ? r_bad_cnt + 32'd1 : '0;
                r_wd_cnt  <= w_chg ? '0 : r_wd_cnt + 32'd1;
                r_lamp    <= (|w_code) ? 6'b010_010 : w_in;
                if (|w_code) begin
                    r_state <= FLASH;
                    r_fault <= 1'b1;
                    r_code  <= w_code;
                    r_tmr   <= '0;
                end
            end else begin
                // Blink phase lives in the yellow lamp registers themselves
                r_tmr  <= w_tog ? '0 : r_tmr + 32'd1;
                r_lamp <= {1'b0, r_lamp[4] ^ w_tog, 2'b00, r_lamp[4] ^ w_tog, 1'b0};
            end
        end
    end
    assign {bus.lamp_red1, bus.lamp_yellow1, bus.lamp_green1, bus.lamp_red2, bus.lamp_yellow2, bus.lamp_green2} = r_lamp;
    assign bus.fault      = r_fault;
    assign bus.fault_code = r_code;
endmodule
